msx_mouse_port: RTL
===================

// Module: msx_mouse_port
// PURPOSE
//  Parametrised MSX mouse protocol engine for one joystick port. Accumulates PS/2 mouse deltas, serves them as
//  4 nibbles (XH,XL,YH,YL) clocked by the MSX STROBE pin, and keeps the residue of clamped motion for later reads.
//  Sits between user_io mouse outputs and the emsx_top joystick pins.
//  Successor to the fixed in-line mouse logic in the MSX top level: adds width/timeout params, saturation, residue, mode force.
// PARAMETERS
//  DELTA_W      9       width of incoming two's-complement mouse_x/mouse_y deltas
//  ACC_W        10      signed accumulator width (must be > DELTA_W-1 and >= 9)
//  TIMEOUT_CYC  100000  clk_sys cycles without STROBE edge before protocol returns to XH
// PORTS
//  clk_sys       in   1        system clock (21.48 MHz)
//  reset         in   1        synchronous, active-high reset
//  mode          in   2        0 auto, 1 force joystick (mouse off), 2 force mouse, 3 = auto
//  mouse_x       in   DELTA_W  X delta, valid on mouse_strobe
//  mouse_y       in   DELTA_W  Y delta, valid on mouse_strobe
//  mouse_flags   in   8        [0] left, [1] right button (1 = pressed)
//  mouse_strobe  in   1        1-cycle pulse: new delta packet
//  joy_n         in   6        active-low joystick state, used for auto-disable
//  msx_str       in   1        STROBE pin from MSX PSG port (same clock domain)
//  mouse_en      out  1        1 = mouse owns the port
//  mouse_n       out  6        pin levels: [3:0] nibble, [5:4] ~buttons; 1 = released/Z
// BEHAVIOUR
//  Reset: mouse_en=0, mouse_n=6'h3F, state=ST_XH, acc_x=acc_y=0, snap=0, timeout=0, str_d=0.
//  mouse_en: mode 1 -> 0; mode 2 -> 1; auto: set on mouse_strobe, else cleared if any joy_n bit 0; strobe wins.
//  mouse_en=0: state forced ST_XH, accumulators cleared, mouse_n=6'h3F.
//  Accumulate: on mouse_strobe acc_x += sext(mouse_x), acc_y += sext(mouse_y); saturate at +/-(2^(ACC_W-1)-1).
//  Edge: str_d <= msx_str each cycle; edge = str_d ^ msx_str. On edge, mouse_n[3:0] valid next cycle (latency 1).
//  ST_XH edge: snap_x = clamp8(-acc_x), snap_y = clamp8(acc_y) (range -127..+127);
//   acc_x += snap_x, acc_y -= snap_y (residue kept); output snap_x[7:4]; -> ST_XL.
//  ST_XL: snap_x[3:0] -> ST_YH; ST_YH: snap_y[7:4] -> ST_YL; ST_YL: snap_y[3:0] -> ST_XH.
//  mouse_strobe in snapshot cycle: acc = acc -/+ snap + delta, then saturate; no motion lost.
//  Timeout: edge loads TIMEOUT_CYC; counter decrements while nonzero; at value 1 state -> ST_XH.
//   Edge in same cycle as timeout==1: edge wins.
//  mouse_n[5:4] <= ~mouse_flags[1:0] every cycle while mouse_en.
//  Reset mid-read: all state to reset values next cycle; pending residue discarded.
// CONFIGURATION
//  MSX_MOUSE_SCALE_EN defined: extra input `scale` [1:0]; deltas arithmetic-shifted right by scale before accumulation
//   (sensitivity divide; -1 >> n stays -1).
//  Not defined: no `scale` port; deltas accumulated unshifted.
// STRUCTURE
//  Package msx_mouse_pkg: typedef enum logic [1:0] {ST_XH,ST_XL,ST_YH,ST_YL} mouse_state_t;
//   typedef enum logic [1:0] {MODE_AUTO,MODE_JOY,MODE_MOUSE} mouse_mode_t; localparam CLAMP8 = 127.
//  Sub-module msx_mouse_acc (saturating signed accumulator: add delta, subtract snapshot, clear), instantiated for X and Y.
// TESTING
//  1 reset asserted 2 cycles -> mouse_en=0, mouse_n=6'h3F; no STROBE response.
//  2 mode=0, strobe x=9'h005, y=9'h1FD; toggle msx_str x4 -> nibbles F,B,F,D; acc 0 after.
//  3 three strobes x=9'h19C (-100) -> acc_x=-300; reads give X 7F,7F,2E; acc_x=0 after third.
//  4 toggle twice (XH,XL), idle TIMEOUT_CYC cycles, toggle -> XH nibble again, not YH.
//  5 mode=0 mouse active, joy_n=6'b111110 -> mouse_en=0 next cycle, mouse_n=3F; mode=2 same stimulus -> stays 1.
//  6 mouse_strobe x=+10 in ST_XH edge cycle with acc_x=-4 -> nibbles 0,4; next read X = -10 (F,6).

Source files
------------

// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX mouse port engine.
package msx_mouse_pkg;

  typedef enum logic [1:0] {
    ST_XH = 2'd0,
    ST_XL = 2'd1,
    ST_YH = 2'd2,
    ST_YL = 2'd3
  } mouse_state_t;

  typedef enum logic [1:0] {
    MODE_AUTO  = 2'd0,
    MODE_JOY   = 2'd1,
    MODE_MOUSE = 2'd2
  } mouse_mode_t;

  localparam int CLAMP8 = 127;

endpackage

// File: rtl/msx_mouse_port_if.sv
// Bus between the PS/2 mouse source / MSX port pins and the mouse engine.
// The scale field exists only when MSX_MOUSE_SCALE_EN is defined.
interface msx_mouse_port_if #(
  parameter int DELTA_W = 9
);
  logic [1:0]         mode;
  logic [DELTA_W-1:0] mouse_x;
  logic [DELTA_W-1:0] mouse_y;
  logic [7:0]         mouse_flags;
  logic               mouse_strobe;
  logic [5:0]         joy_n;
  logic               msx_str;
  logic               mouse_en;
  logic [5:0]         mouse_n;
`ifdef MSX_MOUSE_SCALE_EN
  logic [1:0]         scale;

  modport master (
    output mode, mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_n, msx_str, scale,
    input  mouse_en, mouse_n
  );
  modport slave (
    input  mode, mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_n, msx_str, scale,
    output mouse_en, mouse_n
  );
`else
  modport master (
    output mode, mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_n, msx_str,
    input  mouse_en, mouse_n
  );
  modport slave (
    input  mode, mouse_x, mouse_y, mouse_flags, mouse_strobe, joy_n, msx_str,
    output mouse_en, mouse_n
  );
`endif
endinterface

// File: rtl/msx_mouse_acc.sv
// Saturating signed motion accumulator: adds a delta, removes its own clamped
// snapshot on demand, and reports that clamped (+/-127) value.
module msx_mouse_acc
  import msx_mouse_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    add_i,
  input  logic                    snap_i,
  input  logic signed [ACC_W-1:0] delta_i,
  output logic signed [7:0]       clamp_o
);
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] SAT_HI = $signed({3'b000, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [ACC_W-1:0] C_HI   = ACC_W'(CLAMP8);
  localparam logic signed [ACC_W-1:0] C_LO   = -C_HI;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [7:0]       clamp_s;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [ACC_W-1:0] v);
    return $signed({{2{v[ACC_W-1]}}, v});
  endfunction

  always_comb begin
    if (acc_q > C_HI) begin
      clamp_s = 8'sd127;
    end else if (acc_q < C_LO) begin
      clamp_s = -8'sd127;
    end else begin
      clamp_s = acc_q[7:0];
    end
  end

  // Add and subtract share one sum so a delta arriving with a snapshot is never lost.
  always_comb begin
    sum_s = sext(acc_q);
    if (add_i) begin
      sum_s = sum_s + sext(delta_i);
    end else begin
      sum_s = sum_s;
    end
    if (snap_i) begin
      sum_s = sum_s - $signed({{(SUM_W-8){clamp_s[7]}}, clamp_s});
    end else begin
      sum_s = sum_s;
    end
    if (clr_i) begin
      acc_d = '0;
    end else if (sum_s > SAT_HI) begin
      acc_d = SAT_HI[ACC_W-1:0];
    end else if (sum_s < SAT_LO) begin
      acc_d = SAT_LO[ACC_W-1:0];
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign clamp_o = clamp_s;

endmodule

// File: rtl/msx_mouse_port.sv
// MSX mouse protocol engine for one joystick port: nibble server driven by STROBE.
// Build macro MSX_MOUSE_SCALE_EN adds a per-port delta right-shift (sensitivity divide).
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int DELTA_W     = 9,
  parameter int ACC_W       = 10,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk_sys,
  input  logic            reset,
  msx_mouse_port_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic                    en_q, en_d;
  logic                    str_q;
  logic [5:0]              n_q, n_d;
  mouse_state_t            state_q, state_d;
  logic signed [7:0]       snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    edge_s, snap_s, clr_s, add_s;
  logic signed [ACC_W-1:0] dx_s, dy_s;
  logic signed [7:0]       clamp_x_s, clamp_y_s, neg_x_s;

`ifdef MSX_MOUSE_SCALE_EN
  assign dx_s = $signed(ACC_W'($signed(bus.mouse_x))) >>> bus.scale;
  assign dy_s = $signed(ACC_W'($signed(bus.mouse_y))) >>> bus.scale;
`else
  assign dx_s = $signed(ACC_W'($signed(bus.mouse_x)));
  assign dy_s = $signed(ACC_W'($signed(bus.mouse_y)));
`endif

  assign edge_s = str_q ^ bus.msx_str;
  assign clr_s  = ~en_d;
  assign add_s  = bus.mouse_strobe & en_d;

  // Port ownership: a fresh mouse packet beats a pressed joystick line in auto mode.
  always_comb begin
    case (bus.mode)
      MODE_JOY:   en_d = 1'b0;
      MODE_MOUSE: en_d = 1'b1;
      default: begin
        if (bus.mouse_strobe) begin
          en_d = 1'b1;
        end else if (!(&bus.joy_n)) begin
          en_d = 1'b0;
        end else begin
          en_d = en_q;
        end
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    n_d      = n_q;
    to_d     = to_q;
    snap_s   = 1'b0;
    neg_x_s  = -clamp_x_s;
    if (!en_d) begin
      state_d  = ST_XH;
      snap_x_d = 8'sd0;
      snap_y_d = 8'sd0;
      n_d      = 6'h3F;
      to_d     = '0;
    end else begin
      n_d[5:4] = ~bus.mouse_flags[1:0];
      if (edge_s) begin
        to_d = TO_LOAD;
        // X is reported negated: MSX expects left/up motion as positive.
        case (state_q)
          ST_XH: begin
            snap_s    = 1'b1;
            snap_x_d  = neg_x_s;
            snap_y_d  = clamp_y_s;
            n_d[3:0]  = neg_x_s[7:4];
            state_d   = ST_XL;
          end
          ST_XL: begin
            n_d[3:0] = snap_x_q[3:0];
            state_d  = ST_YH;
          end
          ST_YH: begin
            n_d[3:0] = snap_y_q[7:4];
            state_d  = ST_YL;
          end
          default: begin
            n_d[3:0] = snap_y_q[3:0];
            state_d  = ST_XH;
          end
        endcase
      end else if (to_q != '0) begin
        to_d = to_q - TO_ONE;
        if (to_q == TO_ONE) begin
          state_d = ST_XH;
        end else begin
          state_d = state_q;
        end
      end else begin
        to_d = to_q;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      en_q     <= 1'b0;
      str_q    <= 1'b0;
      n_q      <= 6'h3F;
      state_q  <= ST_XH;
      snap_x_q <= 8'sd0;
      snap_y_q <= 8'sd0;
      to_q     <= '0;
    end else begin
      en_q     <= en_d;
      str_q    <= bus.msx_str;
      n_q      <= n_d;
      state_q  <= state_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
      to_q     <= to_d;
    end
  end

  msx_mouse_acc #(.ACC_W(ACC_W)) u_acc_x (
    .clk     (clk_sys),
    .reset   (reset),
    .clr_i   (clr_s),
    .add_i   (add_s),
    .snap_i  (snap_s),
    .delta_i (dx_s),
    .clamp_o (clamp_x_s)
  );

  msx_mouse_acc #(.ACC_W(ACC_W)) u_acc_y (
    .clk     (clk_sys),
    .reset   (reset),
    .clr_i   (clr_s),
    .add_i   (add_s),
    .snap_i  (snap_s),
    .delta_i (dy_s),
    .clamp_o (clamp_y_s)
  );

  assign bus.mouse_en = en_q;
  assign bus.mouse_n  = n_q;

endmodule
